// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bundle for fetch_stage.
// The fetch stage is the master; the instruction memory is the slave.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC, fetches one word at a time,
// holds it for decode and redirects on jump/branch at retire.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          pcsrc,
    input  logic          jump,
    output logic [31:0]   instr,
    output logic [5:0]    op,
    output logic [5:0]    funct,
    output logic          instr_valid,
    output logic [31:0]   pc,
    output logic [31:0]   pcplus4,
    output logic [31:0]   retire_count
);
    localparam logic [0:0]  S_FETCH = 1'b0;
    localparam logic [0:0]  S_VALID = 1'b1;
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] br_off;
    logic [31:0] jmp_tgt;
    logic [31:0] next_pc;

    assign pc           = pc_q;
    assign pcplus4      = pc_q + 32'd4;
    assign instr        = instr_q;
    assign op           = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign retire_count = cnt_q;
    assign instr_valid  = (state_q == S_VALID);

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;

    // Redirect target: jump beats a taken branch, both beat sequential.
    always_comb begin
        br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jmp_tgt = {pcplus4[31:28], instr_q[25:0], 2'b00};
        if (jump) begin
            next_pc = jmp_tgt;
        end else if (pcsrc) begin
            next_pc = pcplus4 + br_off;
        end else begin
            next_pc = pcplus4;
        end
    end

    // FETCH waits for memory; VALID holds the word until it retires.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State registers; reset drops any held word or pending request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_INIT;
            instr_q <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus
// randomized instruction streams against a behavioural PC model.
module tb_fetch_stage;
    logic        clk;
    logic        reset_n;
    logic        stall, pcsrc, jump;
    logic [31:0] instr, pc, pcplus4, retire_count;
    logic [5:0]  op, funct;
    logic        instr_valid;

    logic        stall2, pcsrc2, jump2;
    logic [31:0] instr2, pc2, pcplus4_2, retire_count2;
    logic [5:0]  op2, funct2;
    logic        instr_valid2;

    int checks;
    int failures;

    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    fetch_stage_if mif ();
    fetch_stage_if jif ();

    fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem         (mif.master),
        .stall        (stall),
        .pcsrc        (pcsrc),
        .jump         (jump),
        .instr        (instr),
        .op           (op),
        .funct        (funct),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .retire_count (retire_count)
    );

    fetch_stage #(.RESET_PC(32'h1000_0023)) dut_j (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem         (jif.master),
        .stall        (stall2),
        .pcsrc        (pcsrc2),
        .jump         (jump2),
        .instr        (instr2),
        .op           (op2),
        .funct        (funct2),
        .instr_valid  (instr_valid2),
        .pc           (pc2),
        .pcplus4      (pcplus4_2),
        .retire_count (retire_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference next-PC, written from the architectural rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur,
                                             input logic [31:0] w,
                                             input bit j, input bit b);
        logic [31:0] p4;
        int signed   off;
        p4 = cur + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
        off = int'($signed(w[15:0]));
        if (b) return p4 + 32'(off * 4);
        return p4;
    endfunction

    // Runs one instruction through fetch, optional stall, and retire.
    task automatic do_instr(input logic [31:0] w, input int waits,
                            input int stalls, input bit j, input bit b);
        logic [31:0] exp_next;
        checks++;
        if (mif.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_state req=%b valid=%b exp req=1 valid=0",
                     mif.imem_req, instr_valid);
        end
        checks++;
        if (mif.imem_addr !== model_pc || pc !== model_pc) begin
            failures++;
            $display("FAIL fetch_addr addr=%h pc=%h exp=%h",
                     mif.imem_addr, pc, model_pc);
        end
        mif.imem_rdata = w;
        for (int i = 0; i < waits; i++) begin
            mif.imem_ready = 1'b0;
            step();
            checks++;
            if (mif.imem_req !== 1'b1 || instr_valid !== 1'b0 ||
                mif.imem_addr !== model_pc) begin
                failures++;
                $display("FAIL wait_state req=%b valid=%b addr=%h exp 1 0 %h",
                         mif.imem_req, instr_valid, mif.imem_addr, model_pc);
            end
        end
        mif.imem_ready = 1'b1;
        stall = (stalls > 0);
        step();
        mif.imem_ready = 1'b0;
        mif.imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || mif.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL valid_state valid=%b req=%b exp valid=1 req=0",
                     instr_valid, mif.imem_req);
        end
        checks++;
        if (instr !== w || op !== w[31:26] || funct !== w[5:0]) begin
            failures++;
            $display("FAIL instr_latch instr=%h op=%h funct=%h exp %h",
                     instr, op, funct, w);
        end
        checks++;
        if (pc !== model_pc || pcplus4 !== model_pc + 32'd4 ||
            retire_count !== model_cnt) begin
            failures++;
            $display("FAIL valid_regs pc=%h p4=%h cnt=%0d exp pc=%h cnt=%0d",
                     pc, pcplus4, retire_count, model_pc, model_cnt);
        end
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            jump = 1'($urandom);
            pcsrc = 1'($urandom);
            mif.imem_ready = 1'($urandom);
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== w || op !== w[31:26] ||
                pc !== model_pc || retire_count !== model_cnt) begin
                failures++;
                $display("FAIL stall_hold valid=%b instr=%h pc=%h cnt=%0d exp %h %h %0d",
                         instr_valid, instr, pc, retire_count, w, model_pc, model_cnt);
            end
        end
        stall = 1'b0;
        jump = j;
        pcsrc = b;
        mif.imem_ready = 1'($urandom);
        exp_next = ref_next(model_pc, w, j, b);
        model_pc = exp_next;
        model_cnt = model_cnt + 32'd1;
        step();
        mif.imem_ready = 1'b0;
        jump = 1'b0;
        pcsrc = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || mif.imem_req !== 1'b1 ||
            mif.imem_addr !== model_pc) begin
            failures++;
            $display("FAIL retire valid=%b req=%b addr=%h exp valid=0 req=1 addr=%h",
                     instr_valid, mif.imem_req, mif.imem_addr, model_pc);
        end
        checks++;
        if (retire_count !== model_cnt) begin
            failures++;
            $display("FAIL retire_count got=%0d exp=%0d", retire_count, model_cnt);
        end
    endtask

    task automatic test_reset;
        #12;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h40 ||
            instr_valid !== 1'b0 || retire_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_out req=%b addr=%h valid=%b cnt=%0d exp 1 40 0 0",
                     mif.imem_req, mif.imem_addr, instr_valid, retire_count);
        end
        checks++;
        if (op !== 6'd0 || funct !== 6'd0 || instr !== 32'd0) begin
            failures++;
            $display("FAIL reset_instr op=%h funct=%h instr=%h exp 0",
                     op, funct, instr);
        end
        checks++;
        if (pc2 !== 32'h1000_0020 || jif.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_pc_align pc=%h req=%b exp 10000020 1",
                     pc2, jif.imem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_pc = 32'h40;
        model_cnt = 32'd0;
    endtask

    task automatic test_jump_precedence;
        jif.imem_rdata = {6'b000010, 26'h000_0100};
        jif.imem_ready = 1'b1;
        step();
        jif.imem_ready = 1'b0;
        checks++;
        if (instr_valid2 !== 1'b1 || op2 !== 6'b000010) begin
            failures++;
            $display("FAIL jump_fetch valid=%b op=%h exp 1 02", instr_valid2, op2);
        end
        jump2 = 1'b1;
        pcsrc2 = 1'b1;
        step();
        jump2 = 1'b0;
        pcsrc2 = 1'b0;
        checks++;
        if (jif.imem_addr !== 32'h1000_0400 || retire_count2 !== 32'd1) begin
            failures++;
            $display("FAIL jump_precedence addr=%h cnt=%0d exp 10000400 1",
                     jif.imem_addr, retire_count2);
        end
    endtask

    task automatic test_sequential;
        logic [5:0]  ops [4];
        logic [31:0] cnt0;
        ops[0] = 6'b000000;
        ops[1] = 6'b100011;
        ops[2] = 6'b101011;
        ops[3] = 6'b001000;
        do_instr({6'b000010, 26'h0}, 0, 0, 1'b1, 1'b0);
        cnt0 = model_cnt;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL seq_pc got=%h exp=%h", pc, 32'(4 * k));
            end
            do_instr({ops[k], 26'($urandom)}, 0, 0, 1'b0, 1'b0);
        end
        checks++;
        if (retire_count !== cnt0 + 32'd4) begin
            failures++;
            $display("FAIL seq_count got=%0d exp=%0d", retire_count, cnt0 + 32'd4);
        end
    endtask

    task automatic test_branch;
        do_instr({6'b000010, 26'h4}, 0, 0, 1'b1, 1'b0);
        do_instr({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 1'b1);
        checks++;
        if (mif.imem_addr !== 32'h0C) begin
            failures++;
            $display("FAIL branch_taken addr=%h exp=0000000c", mif.imem_addr);
        end
        do_instr({6'b000010, 26'h4}, 0, 0, 1'b1, 1'b0);
        do_instr({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 1'b0);
        checks++;
        if (mif.imem_addr !== 32'h14) begin
            failures++;
            $display("FAIL branch_not_taken addr=%h exp=00000014", mif.imem_addr);
        end
    endtask

    task automatic test_wait_stall;
        do_instr({6'b100011, 26'($urandom)}, 3, 4, 1'b0, 1'b0);
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        d = 32'hFFFF_FFF8 - model_pc;
        do_instr({6'b000100, 5'd0, 5'd0, d[17:2]}, 0, 0, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_setup pc=%h exp=fffffffc", pc);
        end
        do_instr(32'($urandom), 1, 0, 1'b0, 1'b0);
        checks++;
        if (mif.imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc addr=%h exp=00000000", mif.imem_addr);
        end
    endtask

    task automatic test_reset_mid_request;
        do_instr({6'b000010, 26'h2}, 0, 0, 1'b1, 1'b0);
        mif.imem_ready = 1'b0;
        step();
        step();
        checks++;
        if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL midreq_setup req=%b addr=%h exp 1 00000008",
                     mif.imem_req, mif.imem_addr);
        end
        #2;
        reset_n = 1'b0;
        mif.imem_rdata = 32'hDEAD_BEEF;
        mif.imem_ready = 1'b1;
        @(posedge clk);
        #1;
        mif.imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || mif.imem_addr !== 32'h40 || instr !== 32'd0) begin
            failures++;
            $display("FAIL midreq_reset valid=%b addr=%h instr=%h exp 0 40 0",
                     instr_valid, mif.imem_addr, instr);
        end
        reset_n = 1'b1;
        model_pc = 32'h40;
        model_cnt = 32'd0;
        step();
        checks++;
        if (instr_valid !== 1'b0 || mif.imem_req !== 1'b1 ||
            mif.imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL midreq_restart valid=%b req=%b addr=%h exp 0 1 40",
                     instr_valid, mif.imem_req, mif.imem_addr);
        end
        do_instr(32'($urandom), 1, 0, 1'b0, 1'b0);
        mif.imem_rdata = 32'h1234_5678;
        mif.imem_ready = 1'b1;
        step();
        mif.imem_ready = 1'b0;
        stall = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || retire_count !== 32'd0 ||
            pc !== 32'h40) begin
            failures++;
            $display("FAIL stall_reset valid=%b instr=%h cnt=%0d pc=%h exp 0 0 0 40",
                     instr_valid, instr, retire_count, pc);
        end
        @(negedge clk);
        stall = 1'b0;
        reset_n = 1'b1;
        model_pc = 32'h40;
        model_cnt = 32'd0;
        do_instr(32'($urandom), 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] w;
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            do_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b1;
        stall = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        stall2 = 1'b0;
        pcsrc2 = 1'b0;
        jump2 = 1'b0;
        mif.imem_ready = 1'b0;
        mif.imem_rdata = 32'd0;
        jif.imem_ready = 1'b0;
        jif.imem_rdata = 32'd0;
        model_pc = 32'h40;
        model_cnt = 32'd0;
        test_reset();
        test_jump_precedence();
        test_sequential();
        test_branch();
        test_wait_stall();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
